// File: rtl/regbank_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : regbank_dump_ctrl_if
// Purpose : valid/ready byte stream from the register dump sequencer.
// Rev     : 1.0
// ============================================================================
interface regbank_dump_ctrl_if #(
  parameter int BYTE_WIDTH = 8
);
  logic [BYTE_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/regbank_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : regbank_dump_ctrl
// Purpose : walks the register bank and streams every word out MSB byte first.
// Rev     : 1.0
// ============================================================================
module regbank_dump_ctrl #(
  parameter int REG_WIDTH     = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int BYTE_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dump_start,
  input  logic                     pipe_write_w,
  input  logic [REG_ADDR_BITS-1:0] pipe_addr_reg_a,
  output logic                     rb_write_w,
  output logic [REG_ADDR_BITS-1:0] rb_addr_reg_a,
  input  logic [REG_WIDTH-1:0]     rb_reg_a_data,
  regbank_dump_ctrl_if.master      tx,
  output logic                     busy,
  output logic                     done
);

  localparam int BYTES = REG_WIDTH / BYTE_WIDTH;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]         LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [REG_ADDR_BITS-1:0] ADDR_MAX  = {REG_ADDR_BITS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [REG_ADDR_BITS-1:0] r_addr;
  logic [REG_ADDR_BITS-1:0] w_addr_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [REG_WIDTH-1:0]     r_shift;
  logic [REG_WIDTH-1:0]     w_shift_nxt;
  logic                     r_valid;
  logic                     w_valid_nxt;
  logic                     r_busy;
  logic                     w_busy_nxt;
  logic                     r_done;
  logic                     w_done_nxt;
  logic                     w_pass;
  logic                     w_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign w_accept = r_valid && tx.tx_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (dump_start) begin
          w_state_nxt = S_ADDR;
          w_addr_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_ADDR: begin
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_shift_nxt = rb_reg_a_data;
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_accept) begin
          if (r_cnt == LAST_BYTE) begin
            w_valid_nxt = 1'b0;
            // Terminate on the last address rather than on counter wrap.
            if (r_addr == ADDR_MAX) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
            end else begin
              w_addr_nxt  = r_addr + 1'b1;
              w_state_nxt = S_ADDR;
            end
          end else begin
            w_shift_nxt = r_shift << BYTE_WIDTH;
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Write must be forced low while dumping: the bank only refreshes read-A then.
  assign w_pass        = (r_state == S_IDLE) || (r_state == S_DONE);
  assign rb_write_w    = w_pass ? pipe_write_w : 1'b0;
  assign rb_addr_reg_a = w_pass ? pipe_addr_reg_a : r_addr;

  assign tx.tx_data  = r_shift[REG_WIDTH-1 -: BYTE_WIDTH];
  assign tx.tx_valid = r_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regbank_dump_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for regbank_dump_ctrl: bank model, byte scoreboard and directed scenarios.
module tb_regbank_dump_ctrl;
  localparam int REG_WIDTH     = 32;
  localparam int REG_ADDR_BITS = 5;
  localparam int BYTE_WIDTH    = 8;
  localparam int NREGS         = 1 << REG_ADDR_BITS;
  localparam int BYTES         = REG_WIDTH / BYTE_WIDTH;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     dump_start = 1'b0;
  logic                     pipe_write_w = 1'b0;
  logic [REG_ADDR_BITS-1:0] pipe_addr_reg_a = '0;
  logic [REG_WIDTH-1:0]     pipe_wdata = '0;
  logic                     rb_write_w;
  logic [REG_ADDR_BITS-1:0] rb_addr_reg_a;
  logic [REG_WIDTH-1:0]     rb_reg_a_data = '0;
  logic                     busy;
  logic                     done;

  regbank_dump_ctrl_if #(.BYTE_WIDTH(BYTE_WIDTH)) tx_if ();

  regbank_dump_ctrl #(
    .REG_WIDTH    (REG_WIDTH),
    .REG_ADDR_BITS(REG_ADDR_BITS),
    .BYTE_WIDTH   (BYTE_WIDTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dump_start     (dump_start),
    .pipe_write_w   (pipe_write_w),
    .pipe_addr_reg_a(pipe_addr_reg_a),
    .rb_write_w     (rb_write_w),
    .rb_addr_reg_a  (rb_addr_reg_a),
    .rb_reg_a_data  (rb_reg_a_data),
    .tx             (tx_if),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Register bank: read-A is registered and only refreshes when not writing.
  logic [REG_WIDTH-1:0] bank [NREGS];
  always @(posedge clk) begin
    if (rb_write_w) bank[rb_addr_reg_a] <= pipe_wdata;
    else            rb_reg_a_data <= bank[rb_addr_reg_a];
  end

  logic [REG_WIDTH-1:0]  exp_mem [NREGS];
  logic [BYTE_WIDTH-1:0] sb [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_dump();
    for (int r = 0; r < NREGS; r++)
      for (int b = 0; b < BYTES; b++)
        sb.push_back(exp_mem[r][REG_WIDTH-1-BYTE_WIDTH*b -: BYTE_WIDTH]);
  endtask

  // Monitor: samples mid-cycle, well after inputs settle and before the next edge.
  int   cyc = 0;
  int   n_acc = 0;
  int   done_cnt = 0;
  int   rise_cyc = 0;
  int   done_cyc = 0;
  logic busy_q = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [BYTE_WIDTH-1:0] eb;
    #2;
    if (!reset) begin
      if (busy && !busy_q) rise_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_in_done", {31'd0, busy}, 32'd0);
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (sb.size() == 0) begin
          chk("sb_size", sb.size(), 32'd1);
        end else begin
          eb = sb.pop_front();
          chk("byte", {24'd0, tx_if.tx_data}, {24'd0, eb});
          n_acc++;
        end
      end
    end
    busy_q = busy;
  end

  task automatic wr(input int a, input logic [REG_WIDTH-1:0] d);
    @(negedge clk);
    pipe_write_w    = 1'b1;
    pipe_addr_reg_a = REG_ADDR_BITS'(a);
    pipe_wdata      = d;
    exp_mem[a]      = d;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_bytes(input int base, input int count, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (n_acc - base == count && tx_if.tx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bytes_reached", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int base;
    int dc;
    tx_if.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_if.tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Pass-through while idle.
    wr(5, 32'hA1B2C3D4);
    #1;
    chk("pt_write_hi", {31'd0, rb_write_w}, 32'd1);
    chk("pt_addr", {27'd0, rb_addr_reg_a}, 32'd5);
    @(negedge clk);
    pipe_write_w = 1'b0;
    #1;
    chk("pt_write_lo", {31'd0, rb_write_w}, 32'd0);
    @(negedge clk);
    chk("pt_rd5", rb_reg_a_data, 32'hA1B2C3D4);
    chk("pt_tx_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    pipe_addr_reg_a = 5'd9;
    #1;
    chk("pt_addr9", {27'd0, rb_addr_reg_a}, 32'd9);

    for (int i = 0; i < NREGS; i++) wr(i, 32'(32'h01010101 * i));
    @(negedge clk);
    pipe_write_w = 1'b0;

    // Full dump, ready held high, restart attempts mid-dump and in the done cycle.
    tx_if.tx_ready = 1'b1;
    push_dump();
    base = n_acc;
    @(negedge clk);
    dump_start      = 1'b1;
    pipe_write_w    = 1'b1;
    pipe_addr_reg_a = 5'd2;
    pipe_wdata      = exp_mem[2];
    #1;
    chk("start_pt_write", {31'd0, rb_write_w}, 32'd1);
    @(negedge clk);
    dump_start   = 1'b0;
    pipe_write_w = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    pulse_start();
    wait_done(400);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    chk("d1_cycles", done_cyc - rise_cyc, 32'd192);
    repeat (20) @(negedge clk);
    chk("d1_done_cnt", done_cnt, 32'd1);
    chk("d1_bytes", n_acc - base, 32'd128);
    chk("d1_sb_empty", sb.size(), 32'd0);
    chk("d1_idle_busy", {31'd0, busy}, 32'd0);

    // Backpressure on byte 2 of reg3, with a blocked pipeline write during the dump.
    wr(3, 32'hDEADBEEF);
    @(negedge clk);
    pipe_write_w = 1'b0;
    push_dump();
    base = n_acc;
    pulse_start();
    wait_bytes(base, 3 * BYTES + 2, 200);
    tx_if.tx_ready  = 1'b0;
    pipe_write_w    = 1'b1;
    pipe_addr_reg_a = 5'd7;
    pipe_wdata      = 32'hFFFFFFFF;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_valid", {31'd0, tx_if.tx_valid}, 32'd1);
      chk("bp_data", {24'd0, tx_if.tx_data}, 32'hBE);
      chk("blk_write", {31'd0, rb_write_w}, 32'd0);
      @(negedge clk);
    end
    tx_if.tx_ready = 1'b1;
    for (int i = 0; i < 200 && (n_acc - base) < 8 * BYTES; i++) @(negedge clk);
    pipe_write_w = 1'b0;
    wait_done(400);
    @(negedge clk);
    chk("d2_sb_empty", sb.size(), 32'd0);
    chk("blk_bank7", bank[7], 32'h07070707);
    chk("d2_done_cnt", done_cnt, 32'd2);

    // Reset after 50 bytes aborts the dump.
    push_dump();
    base = n_acc;
    pulse_start();
    wait_bytes(base, 50, 200);
    reset          = 1'b1;
    tx_if.tx_ready = 1'b0;
    dc             = done_cnt;
    @(negedge clk);
    chk("abort_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    sb.delete();
    pipe_addr_reg_a = 5'd12;
    #1;
    chk("abort_mux", {27'd0, rb_addr_reg_a}, 32'd12);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);

    // Fresh dump restarts from reg0 byte 0.
    tx_if.tx_ready = 1'b1;
    push_dump();
    base = n_acc;
    pulse_start();
    wait_done(400);
    @(negedge clk);
    chk("d4_cycles", done_cyc - rise_cyc, 32'd192);
    chk("d4_bytes", n_acc - base, 32'd128);
    chk("d4_sb_empty", sb.size(), 32'd0);
    chk("total_done", done_cnt, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
